chess_clock_timer: RTL and testbench
====================================

# chess_clock_timer

Two-digit BCD countdown timer for one player of the chess clock; it is the counting stage that sits directly downstream of the debounced switch drivers and upstream of the player's 7-segment digit outputs. It loads a start value from the init switch matrix, decrements once per prescaler period while enabled, and flags zero and low time. An optional per-move bonus adds a fixed number of units at the end of each turn.

## Interface
- p_divider, 17_865_771: clock cycles per count unit (≥2).
- p_low, 5: o_low asserts when value ≤ p_low (binary, 0..99).
- p_bonus, 3: bonus units added per turn end (0..99); used only with the bonus macro.

Ports:
- i_clk  input  1  system clock, 50 MHz domain.
- i_rst  input  1  synchronous, active-low reset.
- i_load  input  1  one-cycle pulse: load i_init, clear prescaler.
- i_init  input  [3:0] x [1:0]  start value; [1] is tens, [0] is units, BCD.
- i_run  input  1  level: counting enabled.
- i_turn_end  input  1  one-cycle pulse: the player finished a move.
- o_digit  output  [3:0] x [1:0]  current value, BCD; [1] is tens.
- o_zero  output  1  value == 00.
- o_low  output  1  value ≤ p_low and not zero.
- o_tick  output  1  one-cycle pulse, asserted in the cycle a decremented value first appears.

## Operation
- State: two BCD digit registers, a prescaler counter of width $clog2(p_divider), and a registered o_tick.
- Load: each i_init digit above 9 is clamped to 9. The prescaler is cleared to 0 and o_tick is 0 in that cycle.
- Load priority: load beats tick and turn_end in the same cycle.
- Prescaler:
  - Counts 0..p_divider-1 while i_run=1 and value≠00.
  - Holds its value while i_run=0.
  - Is held at 0 while value=00.
- Decrement event: the prescaler wraps from p_divider-1 to 0 and value≠00.
  - If units≠0, units is decremented.
  - Otherwise units becomes 9 and tens is decremented.
- Zero is terminal. After 00 the value is not decremented further. Only load or reset leaves 00.
- Bonus (macro only):
  - i_turn_end with value≠00 gives next value = min(99, value + p_bonus).
  - If a decrement coincides, next value = min(99, value − 1 + p_bonus).
  - i_turn_end at 00 is ignored.
- o_zero and o_low are decoded from the digit registers, so they change in the same cycle as o_digit.

## Timing
- Reset (i_rst=0 at a clock edge): digits 00, prescaler 0, o_tick 0. This makes o_zero 1 and o_low 0.
- Load latency: o_digit shows the loaded value on the cycle after i_load is sampled.
- First decrement: it occurs exactly p_divider cycles of i_run=1 after the load edge. Pauses do not lose prescaler progress.
- o_tick is high for exactly one cycle per decrement, aligned with the new o_digit. It also pulses on the 01→00 step.
- Turn-end update: the bonus is visible one cycle after i_turn_end. No o_tick is produced unless a decrement coincides.
- Reset mid-count overrides everything in the same edge.

## Configuration
- Macro CHESS_CLOCK_BONUS_EN.
  - Defined: the bonus adder is built and i_turn_end adds p_bonus as described under Operation.
  - Undefined: i_turn_end is ignored, p_bonus is unused, and no adder logic is synthesised.

## Structure
- Shared package chess_clock_pkg holds:
  - typedef bcd_t (logic [3:0]);
  - typedef bcd2_t (bcd_t [1:0]);
  - constant BCD_MAX = 9 and constant VALUE_MAX = 99;
  - function bcd2_to_bin, used for the o_low compare.
- Sub-module chess_clock_bcd_step: a combinational two-digit BCD decrement-and-optional-add with saturation at 99 and floor at 00. The timer instantiates it once.

## Test plan
- Reset and load:
  - Stimulus: hold i_rst=0, then release; load i_init={2,5} (p_divider=4).
  - Required: o_digit=00 and o_zero=1 during reset; o_digit=25 and o_zero=0 one cycle after the load.
- Run and pause:
  - Stimulus: run from 25 with p_divider=4, pausing i_run for 3 cycles mid-period.
  - Required: 25→24 after 4 running cycles; pause cycles add no progress; one o_tick pulse per step.
- Borrow and zero:
  - Stimulus: load 10 and run.
  - Required: 10→09; o_low asserts at 05 (p_low=5); at 00 o_zero=1, o_low=0, and o_digit stays 00 for 20 further cycles.
- Clamp and priority:
  - Stimulus: load i_init={12,15} with i_turn_end and a prescaler wrap in the same cycle.
  - Required: value 99; no o_tick.
- Bonus (CHESS_CLOCK_BONUS_EN, p_bonus=3):
  - Stimulus 1: at 97, pulse i_turn_end.
  - Required: 99.
  - Stimulus 2: at 07, pulse i_turn_end coincident with a decrement.
  - Required: 09.
  - Stimulus 3: at 00, pulse i_turn_end.
  - Required: stays 00.
- Bonus macro off:
  - Stimulus: identical turn_end stimulus with CHESS_CLOCK_BONUS_EN undefined.
  - Required: value unaffected except by normal decrements.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types and helpers for the chess clock countdown stage.
//   bcd_t       : one BCD digit
//   bcd2_t      : two BCD digits, [1] = tens, [0] = units
//   BCD_MAX     : largest legal BCD digit
//   VALUE_MAX   : largest two-digit value
//   bcd2_to_bin : two-digit BCD to binary
package chess_clock_pkg;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [1:0] bcd2_t;

    localparam bcd_t        BCD_MAX   = 4'd9;
    localparam int unsigned VALUE_MAX = 99;

    function automatic int unsigned bcd2_to_bin(input bcd2_t v);
        return 32'(v[1]) * 32'd10 + 32'(v[0]);
    endfunction

endpackage

// File: rtl/chess_clock_bcd_step.sv
// Combinational next-value stage for the two-digit BCD countdown.
// Decrements by one (floor at 00) when dec_i is set. With CHESS_CLOCK_BONUS_EN
// defined it also adds add_i units afterwards, saturating at 99.
// Ports:
//   value_i : current value, BCD
//   dec_i   : decrement this cycle
//   add_i   : units to add (only with CHESS_CLOCK_BONUS_EN)
//   next_o  : next value, BCD
module chess_clock_bcd_step
    import chess_clock_pkg::*;
(
    input  bcd2_t      value_i,
    input  logic       dec_i,
`ifdef CHESS_CLOCK_BONUS_EN
    input  logic [6:0] add_i,
`endif
    output bcd2_t      next_o
);

`ifdef CHESS_CLOCK_BONUS_EN
    logic [7:0] bin;
    logic [7:0] sum;

    // Work in binary so the add/saturate is a plain compare; 99 + 99 fits in 8 bits.
    always_comb begin
        bin = 8'(bcd2_to_bin(value_i));
        if (dec_i && bin != 8'd0) begin
            bin = bin - 8'd1;
        end
        sum = bin + {1'b0, add_i};
        if (sum > 8'(VALUE_MAX)) begin
            sum = 8'(VALUE_MAX);
        end
        next_o[1] = 4'(sum / 8'd10);
        next_o[0] = 4'(sum % 8'd10);
    end
`else
    always_comb begin
        next_o = value_i;
        if (dec_i && value_i != '0) begin
            if (value_i[0] != 4'd0) begin
                next_o[0] = value_i[0] - 4'd1;
            end else begin
                next_o[0] = BCD_MAX;
                next_o[1] = value_i[1] - 4'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/chess_clock_timer.sv
// One player's two-digit BCD countdown timer for the chess clock.
// Loads a clamped start value, decrements once per p_divider running cycles,
// stops at 00 and flags zero / low time. Optional per-move bonus under the
// macro CHESS_CLOCK_BONUS_EN.
// Ports:
//   i_clk      : system clock
//   i_rst      : synchronous active-low reset
//   i_load     : pulse, load i_init and clear the prescaler
//   i_init     : start value, BCD, [1] = tens
//   i_run      : level, counting enabled
//   i_turn_end : pulse, move finished (bonus only)
//   o_digit    : current value, BCD, [1] = tens
//   o_zero     : value == 00
//   o_low      : 0 < value <= p_low
//   o_tick     : one-cycle pulse with each newly decremented value
module chess_clock_timer
    import chess_clock_pkg::*;
#(
    parameter int unsigned p_divider = 17_865_771,
    parameter int unsigned p_low     = 5,
    parameter int unsigned p_bonus   = 3
)(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  bcd2_t i_init,
    input  logic  i_run,
    input  logic  i_turn_end,
    output bcd2_t o_digit,
    output logic  o_zero,
    output logic  o_low,
    output logic  o_tick
);

    localparam int unsigned     PW         = $clog2(p_divider);
    localparam logic [PW-1:0] PRESC_LAST = PW'(p_divider - 1);

    bcd2_t         digit_q;
    bcd2_t         digit_step;
    logic [PW-1:0] presc_q;
    logic          tick_q;
    logic          zero;
    logic          wrap;

    function automatic bcd_t clamp_bcd(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    assign zero = (digit_q == '0);
    // Prescaler only advances while running and non-zero, so wrap implies a decrement.
    assign wrap = i_run && !zero && (presc_q == PRESC_LAST);

`ifdef CHESS_CLOCK_BONUS_EN
    logic [6:0] bonus_add;
    assign bonus_add = (i_turn_end && !zero) ? 7'(p_bonus) : 7'd0;

    chess_clock_bcd_step u_step (
        .value_i (digit_q),
        .dec_i   (wrap),
        .add_i   (bonus_add),
        .next_o  (digit_step)
    );
`else
    logic [7:0] unused_cfg;
    assign unused_cfg = {i_turn_end, 7'(p_bonus)};

    chess_clock_bcd_step u_step (
        .value_i (digit_q),
        .dec_i   (wrap),
        .next_o  (digit_step)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            digit_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (i_load) begin
            digit_q[1] <= clamp_bcd(i_init[1]);
            digit_q[0] <= clamp_bcd(i_init[0]);
            presc_q    <= '0;
            tick_q     <= 1'b0;
        end else begin
            digit_q <= digit_step;
            tick_q  <= wrap;
            if (zero || wrap) begin
                presc_q <= '0;
            end else if (i_run) begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign o_digit = digit_q;
    assign o_zero  = zero;
    assign o_low   = !zero && (bcd2_to_bin(digit_q) <= p_low);
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_chess_clock_timer.sv
module tb_chess_clock_timer;
    import chess_clock_pkg::*;

    localparam int DIV   = 4;
    localparam int LOW   = 5;
    localparam int BONUS = 3;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  load = 1'b0;
    bcd2_t init = '0;
    logic  run = 1'b0;
    logic  turn_end = 1'b0;
    bcd2_t o_digit;
    logic  o_zero;
    logic  o_low;
    logic  o_tick;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: value as a plain integer, running-cycle count since last step.
    int m_val = 0;
    int m_cnt = 0;
    bit m_tick = 1'b0;

    always #5 clk = ~clk;

    chess_clock_timer #(
        .p_divider (DIV),
        .p_low     (LOW),
        .p_bonus   (BONUS)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (load),
        .i_init     (init),
        .i_run      (run),
        .i_turn_end (turn_end),
        .o_digit    (o_digit),
        .o_zero     (o_zero),
        .o_low      (o_low),
        .o_tick     (o_tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit_val(input string name, input int tens, input int units);
        chk(name, {24'd0, o_digit[1], o_digit[0]}, tens * 16 + units);
    endtask

    always @(posedge clk) begin : model
        int nv;
        int nc;
        int t;
        int u;
        bit dec;
        nv  = m_val;
        nc  = m_cnt;
        dec = 1'b0;
        if (!rst) begin
            nv = 0;
            nc = 0;
        end else if (load) begin
            t  = int'(init[1]);
            u  = int'(init[0]);
            nv = (t > 9 ? 9 : t) * 10 + (u > 9 ? 9 : u);
            nc = 0;
        end else begin
            if (m_val == 0) begin
                nc = 0;
            end else if (run) begin
                nc = m_cnt + 1;
                if (nc == DIV) begin
                    nc  = 0;
                    dec = 1'b1;
                end
            end
            nv = m_val - (dec ? 1 : 0);
`ifdef CHESS_CLOCK_BONUS_EN
            if (turn_end && m_val != 0) begin
                nv = (nv + BONUS > 99) ? 99 : nv + BONUS;
            end
`endif
        end
        m_val  <= nv;
        m_cnt  <= nc;
        m_tick <= dec;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("digit", {24'd0, o_digit[1], o_digit[0]}, (m_val / 10) * 16 + m_val % 10);
            chk("zero", {31'd0, o_zero}, (m_val == 0) ? 1 : 0);
            chk("low", {31'd0, o_low}, (m_val != 0 && m_val <= LOW) ? 1 : 0);
            chk("tick", {31'd0, o_tick}, m_tick ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int t, input int u);
        load    = 1'b1;
        init[1] = 4'(t);
        init[0] = 4'(u);
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        // Reset
        cyc(1);
        cyc(1);
        cmp_en = 1'b1;
        lit_val("reset_digit", 0, 0);
        chk("reset_zero", {31'd0, o_zero}, 1);
        chk("reset_low", {31'd0, o_low}, 0);
        cyc(1);
        rst = 1'b1;
        cyc(1);

        // Load 25
        do_load(2, 5);
        lit_val("load_25", 2, 5);
        chk("load_zero", {31'd0, o_zero}, 0);

        // Run 2, pause 3, run 2: step lands on the 4th running cycle
        run = 1'b1;
        cyc(2);
        run = 1'b0;
        cyc(3);
        run = 1'b1;
        cyc(1);
        lit_val("pause_hold_25", 2, 5);
        chk("pause_no_tick", {31'd0, o_tick}, 0);
        cyc(1);
        lit_val("step_24", 2, 4);
        chk("step_tick", {31'd0, o_tick}, 1);
        cyc(1);
        chk("tick_one_cycle", {31'd0, o_tick}, 0);

        // Borrow and zero
        do_load(1, 0);
        cyc(4);
        lit_val("borrow_09", 0, 9);
        cyc(16);
        lit_val("low_05", 0, 5);
        chk("low_asserted", {31'd0, o_low}, 1);
        cyc(20);
        lit_val("reach_00", 0, 0);
        chk("zero_tick", {31'd0, o_tick}, 1);
        chk("zero_flag", {31'd0, o_zero}, 1);
        chk("zero_not_low", {31'd0, o_low}, 0);
        cyc(20);
        lit_val("zero_terminal", 0, 0);

        // Clamp and priority: load coincides with a wrap and turn_end
        do_load(2, 5);
        cyc(3);
        turn_end = 1'b1;
        do_load(12, 15);
        turn_end = 1'b0;
        lit_val("clamp_99", 9, 9);
        chk("clamp_no_tick", {31'd0, o_tick}, 0);

        // Bonus at 97
        cyc(8);
        lit_val("at_97", 9, 7);
        turn_end = 1'b1;
        cyc(1);
        turn_end = 1'b0;
`ifdef CHESS_CLOCK_BONUS_EN
        lit_val("bonus_sat_99", 9, 9);
`else
        lit_val("no_bonus_97", 9, 7);
`endif
        chk("bonus_no_tick", {31'd0, o_tick}, 0);

        // Bonus coinciding with a decrement at 07
        do_load(0, 7);
        cyc(3);
        turn_end = 1'b1;
        cyc(1);
        turn_end = 1'b0;
`ifdef CHESS_CLOCK_BONUS_EN
        lit_val("bonus_dec_09", 0, 9);
`else
        lit_val("no_bonus_dec_06", 0, 6);
`endif
        chk("bonus_dec_tick", {31'd0, o_tick}, 1);

        // turn_end at 00 is ignored
        run = 1'b0;
        do_load(0, 0);
        turn_end = 1'b1;
        cyc(1);
        turn_end = 1'b0;
        lit_val("bonus_at_zero", 0, 0);
        cyc(2);

        // Reset mid-count
        run = 1'b1;
        do_load(5, 0);
        cyc(2);
        rst = 1'b0;
        turn_end = 1'b1;
        cyc(1);
        turn_end = 1'b0;
        lit_val("mid_reset_00", 0, 0);
        chk("mid_reset_tick", {31'd0, o_tick}, 0);
        rst = 1'b1;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
